// File: rtl/decryption.sv
// -----------------------------------------------------------------------------
// decryption -- iterative AES-128 decryption core, one round per clock.
//
// The key schedule is first run forward from the cipher key to round key 10.
// It is then run backward on the fly, one step per inverse round, so no
// round-key storage is needed. Byte substitutions are evaluated with the
// combinational aes_sbox / aes_inv_sbox functions defined locally.
//
// Ports:
//   clock             in   1    rising-edge clock
//   resetModule       in   1    asynchronous reset, active low
//   inputData         in   128  ciphertext, byte 0 in [127:120]
//   key               in   128  cipher key, same byte order
//   inputsLoadedFlag  in   1    request level, sampled only in IDLE
//   outputData        out  128  plaintext, registered, held until next result
//   dataDecryptedFlag out  1    result valid, registered
//
// Handshake: a request is taken on the first rising edge in IDLE where
// inputsLoadedFlag=1; ciphertext and key are captured on that edge only.
// dataDecryptedFlag rises with outputData and stays high while
// inputsLoadedFlag=1; it drops on the first edge that sees the request low,
// so a held request produces exactly one decryption.
//
// Optional feature macro: DECRYPTION_KEY_CACHE_EN. When defined, the last
// expanded cipher key and its round key 10 are cached; a request with the
// same key skips KEY_EXPAND (11-cycle latency instead of 21).
//
// The FSM state is held in fsm_q (type state_e) for observation by checkers.
// -----------------------------------------------------------------------------
module decryption (
  input  logic         clock,
  input  logic         resetModule,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  input  logic         inputsLoadedFlag,
  output logic [127:0] outputData,
  output logic         dataDecryptedFlag
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_KEY_EXPAND = 3'd1,
    S_INIT_ADD   = 3'd2,
    S_ROUNDS     = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, polynomial 0x11B
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e       fsm_q;
  logic [127:0] state_q;
  logic [127:0] round_key_q;
  logic [3:0]   cnt_q;        // keyCnt during KEY_EXPAND, rnd during ROUNDS
  logic [127:0] out_data_q;
  logic         done_q;

`ifdef DECRYPTION_KEY_CACHE_EN
  logic [127:0] key_cap_q;    // cipher key of the run in progress
  logic [127:0] cache_key_q;
  logic [127:0] cache_k10_q;
  logic         cache_vld_q;
`endif

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  rcon_w;
  logic [127:0] fwd_key;
  logic [127:0] prev_key;
  logic [127:0] isr;          // InvShiftRows then InvSubBytes
  logic [127:0] ark;
  logic [127:0] mixed;
  logic [127:0] round_out;

  always_comb begin
    // One SubWord(RotWord()) is shared: forward expansion feeds it the old w3,
    // backward expansion feeds it the recovered w3 = w7 ^ w6.
    sub_in  = (fsm_q == S_ROUNDS) ? (round_key_q[31:0] ^ round_key_q[63:32])
                                  : round_key_q[31:0];
    sub_out = {aes_sbox(sub_in[23:16]), aes_sbox(sub_in[15:8]),
               aes_sbox(sub_in[7:0]),   aes_sbox(sub_in[31:24])};
    rcon_w  = {rcon(cnt_q), 24'h000000};

    fwd_key[127:96] = round_key_q[127:96] ^ sub_out ^ rcon_w;
    fwd_key[95:64]  = round_key_q[95:64]  ^ fwd_key[127:96];
    fwd_key[63:32]  = round_key_q[63:32]  ^ fwd_key[95:64];
    fwd_key[31:0]   = round_key_q[31:0]   ^ fwd_key[63:32];

    prev_key[127:96] = round_key_q[127:96] ^ sub_out ^ rcon_w;
    prev_key[95:64]  = round_key_q[95:64]  ^ round_key_q[127:96];
    prev_key[63:32]  = round_key_q[63:32]  ^ round_key_q[95:64];
    prev_key[31:0]   = round_key_q[31:0]   ^ round_key_q[63:32];

    // Byte i = row (i%4), column (i/4); row r is rotated right by r columns.
    isr = '0;
    for (int i = 0; i < 16; i++) begin
      isr[127 - 8*i -: 8] =
        aes_inv_sbox(state_q[127 - 8*((i % 4) + 4*(((i / 4) - (i % 4) + 4) % 4)) -: 8]);
    end

    ark = isr ^ prev_key;

    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
    end

    // The last inverse round (rnd=1) has no InvMixColumns.
    round_out = (cnt_q == 4'd1) ? ark : mixed;
  end

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetModule) begin
    if (!resetModule) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      round_key_q <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef DECRYPTION_KEY_CACHE_EN
      key_cap_q   <= '0;
      cache_key_q <= '0;
      cache_k10_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (inputsLoadedFlag) begin
            state_q <= inputData;
`ifdef DECRYPTION_KEY_CACHE_EN
            key_cap_q <= key;
            if (cache_vld_q && (key == cache_key_q)) begin
              round_key_q <= cache_k10_q;
              fsm_q       <= S_INIT_ADD;
            end else begin
              round_key_q <= key;
              cnt_q       <= 4'd1;
              fsm_q       <= S_KEY_EXPAND;
            end
`else
            round_key_q <= key;
            cnt_q       <= 4'd1;
            fsm_q       <= S_KEY_EXPAND;
`endif
          end
        end

        S_KEY_EXPAND: begin
          round_key_q <= fwd_key;
          cnt_q       <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            fsm_q <= S_INIT_ADD;
`ifdef DECRYPTION_KEY_CACHE_EN
            cache_key_q <= key_cap_q;
            cache_k10_q <= fwd_key;
            cache_vld_q <= 1'b1;
`endif
          end
        end

        S_INIT_ADD: begin
          state_q <= state_q ^ round_key_q;
          cnt_q   <= 4'd10;
          fsm_q   <= S_ROUNDS;
        end

        S_ROUNDS: begin
          state_q     <= round_out;
          round_key_q <= prev_key;
          cnt_q       <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            out_data_q <= round_out;
            done_q     <= 1'b1;
            fsm_q      <= S_DONE;
          end
        end

        S_DONE: begin
          // Wait for the request to be seen low before accepting another.
          if (!inputsLoadedFlag) begin
            done_q <= 1'b0;
            fsm_q  <= S_IDLE;
          end
        end

        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign outputData        = out_data_q;
  assign dataDecryptedFlag = done_q;

endmodule
